// File: rtl/display_timings_pkg.sv
// Shared timing-set type and the two standard video modes.
package display_timings_pkg;

    typedef struct packed {
        logic [15:0] h_res;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_res;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        h_pol;
        logic        v_pol;
    } timing_cfg_t;

    localparam timing_cfg_t TIMING_640X480 = '{
        h_res: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
        v_res: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
        h_pol: 1'b0,    v_pol: 1'b0
    };

    localparam timing_cfg_t TIMING_1280X720 = '{
        h_res: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
        v_res: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20,
        h_pol: 1'b1,     v_pol: 1'b1
    };

    // Total blanking length of one axis (front porch + sync + back porch).
    function automatic int blank(input logic [15:0] fp, input logic [15:0] sync,
                                 input logic [15:0] bp);
        return int'(fp) + int'(sync) + int'(bp);
    endfunction

endpackage

// File: rtl/display_timings_prog_if.sv
// Valid/ready channel carrying a new timing set into the generator.
interface display_timings_prog_if;
    import display_timings_pkg::*;

    logic        cfg_valid;
    timing_cfg_t cfg;
    logic        cfg_ready;

    modport master (output cfg_valid, output cfg, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg, output cfg_ready);
endinterface

// File: rtl/display_timings_bounds.sv
// Holds the derived boundaries of the pending and active timing sets so the
// counter compares against registers instead of adder outputs.
module display_timings_bounds
    import display_timings_pkg::*;
#(
    parameter int          CORDW   = 16,
    parameter timing_cfg_t DEF_CFG = TIMING_640X480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  timing_cfg_t             cfg,
    input  logic                    apply,
    output logic signed [CORDW-1:0] h_sta,
    output logic signed [CORDW-1:0] hs_sta,
    output logic signed [CORDW-1:0] hs_end,
    output logic signed [CORDW-1:0] ha_end,
    output logic signed [CORDW-1:0] v_sta,
    output logic signed [CORDW-1:0] vs_sta,
    output logic signed [CORDW-1:0] vs_end,
    output logic signed [CORDW-1:0] va_end,
    output logic                    h_pol,
    output logic                    v_pol,
    output logic signed [CORDW-1:0] nxt_h_sta,
    output logic signed [CORDW-1:0] nxt_v_sta
);

    typedef struct packed {
        logic signed [CORDW-1:0] h_sta;
        logic signed [CORDW-1:0] hs_sta;
        logic signed [CORDW-1:0] hs_end;
        logic signed [CORDW-1:0] ha_end;
        logic signed [CORDW-1:0] v_sta;
        logic signed [CORDW-1:0] vs_sta;
        logic signed [CORDW-1:0] vs_end;
        logic signed [CORDW-1:0] va_end;
        logic                    h_pol;
        logic                    v_pol;
    } bnd_t;

    function automatic bnd_t derive(input timing_cfg_t c);
        bnd_t b;
        int   hs;
        int   vs;
        hs       = -blank(c.h_fp, c.h_sync, c.h_bp);
        vs       = -blank(c.v_fp, c.v_sync, c.v_bp);
        b.h_sta  = CORDW'(hs);
        b.hs_sta = CORDW'(hs + int'(c.h_fp));
        b.hs_end = CORDW'(hs + int'(c.h_fp) + int'(c.h_sync));
        b.ha_end = CORDW'(int'(c.h_res) - 1);
        b.v_sta  = CORDW'(vs);
        b.vs_sta = CORDW'(vs + int'(c.v_fp));
        b.vs_end = CORDW'(vs + int'(c.v_fp) + int'(c.v_sync));
        b.va_end = CORDW'(int'(c.v_res) - 1);
        b.h_pol  = c.h_pol;
        b.v_pol  = c.v_pol;
        return b;
    endfunction

    localparam bnd_t DEF_B = derive(DEF_CFG);

    bnd_t act;
    bnd_t pend;

    // The pending copy is qualified by the pending flag in the top, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) pend <= derive(cfg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     act <= DEF_B;
        else if (apply) act <= pend;
    end

    assign h_sta     = act.h_sta;
    assign hs_sta    = act.hs_sta;
    assign hs_end    = act.hs_end;
    assign ha_end    = act.ha_end;
    assign v_sta     = act.v_sta;
    assign vs_sta    = act.vs_sta;
    assign vs_end    = act.vs_end;
    assign va_end    = act.va_end;
    assign h_pol     = act.h_pol;
    assign v_pol     = act.v_pol;
    assign nxt_h_sta = pend.h_sta;
    assign nxt_v_sta = pend.v_sta;

endmodule

// File: rtl/display_timings_prog.sv
// Programmable display timing generator: counts x/y over the active timing set
// and swaps in a newly offered set only at a frame boundary.
module display_timings_prog
    import display_timings_pkg::*;
#(
    parameter int          CORDW   = 16,
    parameter int          FCW     = 16,
    parameter timing_cfg_t DEF_CFG = TIMING_640X480
) (
    input  logic                    clk_pix,
    input  logic                    rst_n,
    display_timings_prog_if.slave   cfg_bus,
    input  logic signed [CORDW-1:0] irq_line,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame,
    output logic                    line,
    output logic                    line_irq,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy,
    output logic [FCW-1:0]          frame_cnt
);

    localparam logic signed [CORDW-1:0] H_STA0 =
        CORDW'(-blank(DEF_CFG.h_fp, DEF_CFG.h_sync, DEF_CFG.h_bp));
    localparam logic signed [CORDW-1:0] V_STA0 =
        CORDW'(-blank(DEF_CFG.v_fp, DEF_CFG.v_sync, DEF_CFG.v_bp));
    localparam logic signed [CORDW-1:0] ONE = CORDW'(1);

    logic [1:0] rst_sr;
    logic       rst_i;

    // Assert asynchronously, release two clk_pix edges later.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) rst_sr <= 2'b00;
        else        rst_sr <= {rst_sr[0], 1'b1};
    end
    assign rst_i = rst_sr[1];

    logic signed [CORDW-1:0] x, y;
    logic signed [CORDW-1:0] h_sta, hs_sta, hs_end, ha_end;
    logic signed [CORDW-1:0] v_sta, vs_sta, vs_end, va_end;
    logic signed [CORDW-1:0] nxt_h_sta, nxt_v_sta;
    logic                    h_pol, v_pol;
    logic                    pending, accept, apply;

    assign cfg_bus.cfg_ready = ~pending;
    assign accept            = cfg_bus.cfg_valid && !pending;
    assign apply             = pending && (x == ha_end) && (y == va_end);

    display_timings_bounds #(.CORDW(CORDW), .DEF_CFG(DEF_CFG)) u_bounds (
        .clk       (clk_pix),
        .rst_n     (rst_i),
        .load      (accept),
        .cfg       (cfg_bus.cfg),
        .apply     (apply),
        .h_sta     (h_sta),
        .hs_sta    (hs_sta),
        .hs_end    (hs_end),
        .ha_end    (ha_end),
        .v_sta     (v_sta),
        .vs_sta    (vs_sta),
        .vs_end    (vs_end),
        .va_end    (va_end),
        .h_pol     (h_pol),
        .v_pol     (v_pol),
        .nxt_h_sta (nxt_h_sta),
        .nxt_v_sta (nxt_v_sta)
    );

    always_ff @(posedge clk_pix or negedge rst_i) begin
        if (!rst_i) begin
            pending   <= 1'b0;
            x         <= H_STA0;
            y         <= V_STA0;
            sx        <= H_STA0;
            sy        <= V_STA0;
            hsync     <= ~DEF_CFG.h_pol;
            vsync     <= ~DEF_CFG.v_pol;
            de        <= 1'b0;
            frame     <= 1'b0;
            line      <= 1'b0;
            line_irq  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (accept)     pending <= 1'b1;
            else if (apply) pending <= 1'b0;

            // On the apply cycle the wrap targets come from the pending set.
            if (x == ha_end) begin
                x <= apply ? nxt_h_sta : h_sta;
                if (y == va_end) y <= apply ? nxt_v_sta : v_sta;
                else             y <= y + ONE;
            end else begin
                x <= x + ONE;
            end

            sx        <= x;
            sy        <= y;
            hsync     <= (x > hs_sta && x <= hs_end) ? h_pol : ~h_pol;
            vsync     <= (y > vs_sta && y <= vs_end) ? v_pol : ~v_pol;
            de        <= (y >= 0) && (x >= 0);
            frame     <= (y == v_sta) && (x == h_sta);
            line      <= (y >= 0) && (x == h_sta);
            line_irq  <= (y >= 0) && (x == h_sta) && (y == irq_line);
            frame_cnt <= frame_cnt + FCW'(frame);
        end
    end

endmodule

// File: tb/tb_display_timings_prog.sv
// Bench for display_timings_prog: default-mode checks on one instance and a
// cycle-level reference model driving random timing sets into a second one.
module tb_display_timings_prog;
    import display_timings_pkg::*;

    localparam timing_cfg_t S0 = '{
        h_res: 16'd8, h_fp: 16'd2, h_sync: 16'd3, h_bp: 16'd1,
        v_res: 16'd4, v_fp: 16'd1, v_sync: 16'd2, v_bp: 16'd1,
        h_pol: 1'b1,  v_pol: 1'b0
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n, rst2_n;
    logic signed [15:0] irq1, irq2;

    display_timings_prog_if bus1();
    display_timings_prog_if bus2();

    logic d1_hs, d1_vs, d1_de, d1_fr, d1_ln, d1_irq;
    logic signed [15:0] d1_sx, d1_sy;
    logic [15:0] d1_fc;
    logic d2_hs, d2_vs, d2_de, d2_fr, d2_ln, d2_irq;
    logic signed [15:0] d2_sx, d2_sy;
    logic [1:0] d2_fc;

    display_timings_prog dut1 (
        .clk_pix(clk), .rst_n(rst1_n), .cfg_bus(bus1.slave), .irq_line(irq1),
        .hsync(d1_hs), .vsync(d1_vs), .de(d1_de), .frame(d1_fr), .line(d1_ln),
        .line_irq(d1_irq), .sx(d1_sx), .sy(d1_sy), .frame_cnt(d1_fc)
    );

    display_timings_prog #(.CORDW(16), .FCW(2), .DEF_CFG(S0)) dut2 (
        .clk_pix(clk), .rst_n(rst2_n), .cfg_bus(bus2.slave), .irq_line(irq2),
        .hsync(d2_hs), .vsync(d2_vs), .de(d2_de), .frame(d2_fr), .line(d2_ln),
        .line_irq(d2_irq), .sx(d2_sx), .sy(d2_sy), .frame_cnt(d2_fc)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Reference model: position is a cycle index into the frame of the active set.
    timing_cfg_t m_act, m_nxt;
    bit m_pend;
    int m_t, m_fc;

    function automatic int total_of(input timing_cfg_t c);
        return (int'(c.h_res) + blank(c.h_fp, c.h_sync, c.h_bp)) *
               (int'(c.v_res) + blank(c.v_fp, c.v_sync, c.v_bp));
    endfunction

    function automatic timing_cfg_t rand_cfg();
        timing_cfg_t c;
        c.h_res  = 16'($urandom_range(10, 2));
        c.h_fp   = 16'($urandom_range(3, 0));
        c.h_sync = 16'($urandom_range(4, 1));
        c.h_bp   = 16'($urandom_range(3, 0));
        c.v_res  = 16'($urandom_range(6, 2));
        c.v_fp   = 16'($urandom_range(2, 0));
        c.v_sync = 16'($urandom_range(2, 1));
        c.v_bp   = 16'($urandom_range(2, 0));
        c.h_pol  = 1'($urandom_range(1, 0));
        c.v_pol  = 1'($urandom_range(1, 0));
        return c;
    endfunction

    task automatic check2();
        int hsta, vsta, htot, tot, x, y, hp, vp;
        logic e_hs, e_vs, e_irq;
        bit acc, app;
        hsta = -blank(m_act.h_fp, m_act.h_sync, m_act.h_bp);
        vsta = -blank(m_act.v_fp, m_act.v_sync, m_act.v_bp);
        htot = int'(m_act.h_res) - hsta;
        tot  = total_of(m_act);
        x    = hsta + m_t % htot;
        y    = vsta + m_t / htot;
        hp   = hsta + int'(m_act.h_fp);
        vp   = vsta + int'(m_act.v_fp);
        e_hs = (x > hp && x <= hp + int'(m_act.h_sync)) ? m_act.h_pol : !m_act.h_pol;
        e_vs = (y > vp && y <= vp + int'(m_act.v_sync)) ? m_act.v_pol : !m_act.v_pol;
        e_irq = (y >= 0) && (x == hsta) && (y == int'(irq2));
        acc  = bus2.cfg_valid && !m_pend;
        app  = m_pend && (m_t == tot - 1);
        chk("sx", 32'(d2_sx), 32'(x));
        chk("sy", 32'(d2_sy), 32'(y));
        chk("hsync", 32'(d2_hs), 32'(e_hs));
        chk("vsync", 32'(d2_vs), 32'(e_vs));
        chk("de", 32'(d2_de), 32'(x >= 0 && y >= 0));
        chk("frame", 32'(d2_fr), 32'(m_t == 0));
        chk("line", 32'(d2_ln), 32'(y >= 0 && x == hsta));
        chk("line_irq", 32'(d2_irq), 32'(e_irq));
        chk("frame_cnt", 32'(d2_fc), 32'(m_fc % 4));
        chk("cfg_ready", 32'(bus2.cfg_ready), 32'(!(acc || (m_pend && !app))));
        if (m_t == 0) m_fc++;
        m_t = (m_t + 1) % tot;
        if (acc) begin
            m_pend = 1'b1;
            m_nxt  = bus2.cfg;
        end else if (app) begin
            m_pend = 1'b0;
            m_act  = m_nxt;
        end
    endtask

    task automatic step2();
        @(posedge clk); #1;
        check2();
    endtask

    task automatic run2(input int n);
        for (int i = 0; i < n; i++) step2();
    endtask

    task automatic offer2(input timing_cfg_t c);
        bus2.cfg       = c;
        bus2.cfg_valid = 1'b1;
        step2();
        bus2.cfg_valid = 1'b0;
    endtask

    task automatic wait_apply2(input int bound);
        int n = 0;
        while (m_pend && n < bound) begin
            step2();
            n++;
        end
        chk("apply_reached", 32'(m_pend), 32'(0));
    endtask

    task automatic wait_frame1();
        int n = 0;
        while (d1_fr !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("d1_first_frame", 32'(d1_fr), 32'(1));
    endtask

    task automatic line1();
        int lo = 0;
        for (int i = 0; i < 800; i++) begin
            if (d1_hs === 1'b0) lo++;
            @(posedge clk); #1;
        end
        chk("d1_wrap_sx", 32'(d1_sx), 32'(-160));
        chk("d1_wrap_sy", 32'(d1_sy), 32'(-44));
        chk("d1_hsync_low", 32'(lo), 32'(96));
    endtask

    task automatic chk_reset1();
        chk("rst_sx", 32'(d1_sx), 32'(-160));
        chk("rst_sy", 32'(d1_sy), 32'(-45));
        chk("rst_hsync", 32'(d1_hs), 32'(1));
        chk("rst_vsync", 32'(d1_vs), 32'(1));
        chk("rst_de", 32'(d1_de), 32'(0));
        chk("rst_frame", 32'(d1_fr), 32'(0));
        chk("rst_line", 32'(d1_ln), 32'(0));
        chk("rst_irq", 32'(d1_irq), 32'(0));
        chk("rst_fcnt", 32'(d1_fc), 32'(0));
        chk("rst_ready", 32'(bus1.cfg_ready), 32'(1));
    endtask

    initial begin
        int n, cnt;
        timing_cfg_t a;
        rst1_n = 1'b0; rst2_n = 1'b0;
        irq1 = 16'sd100; irq2 = 16'sd1;
        bus1.cfg_valid = 1'b0; bus1.cfg = TIMING_640X480;
        bus2.cfg_valid = 1'b0; bus2.cfg = S0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset1();

        // Default 640x480 after reset.
        rst1_n = 1'b1;
        wait_frame1();
        chk("d1_frame_sx", 32'(d1_sx), 32'(-160));
        chk("d1_frame_sy", 32'(d1_sy), 32'(-45));
        chk("d1_frame_fcnt", 32'(d1_fc), 32'(0));
        line1();

        // Pending set discarded by a mid-line reset.
        bus1.cfg = TIMING_1280X720;
        bus1.cfg_valid = 1'b1;
        @(posedge clk); #1;
        bus1.cfg_valid = 1'b0;
        chk("d1_ready_drop", 32'(bus1.cfg_ready), 32'(0));
        repeat (37) @(posedge clk);
        #3;
        rst1_n = 1'b0;
        #1;
        chk_reset1();
        repeat (2) @(posedge clk);
        #1;
        rst1_n = 1'b1;
        wait_frame1();
        chk("d1_ready_after_rst", 32'(bus1.cfg_ready), 32'(1));
        line1();

        // Model-checked instance with small timing sets.
        m_act = S0; m_nxt = S0; m_pend = 1'b0; m_t = 0; m_fc = 0;
        rst2_n = 1'b1;
        n = 0;
        while (d2_fr !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("d2_first_frame", 32'(d2_fr), 32'(1));
        check2();
        irq2 = 16'sd2;  run2(3 * total_of(S0));
        irq2 = 16'sd4;  run2(total_of(S0));
        irq2 = -16'sd1; run2(total_of(S0));
        irq2 = 16'sd1;

        // Mid-frame offer, then a second offer while pending.
        for (int k = 0; k < 3; k++) begin
            run2(int'($urandom_range(40, 3)));
            a = rand_cfg();
            offer2(a);
            run2(int'($urandom_range(6, 1)));
            offer2(rand_cfg());
            wait_apply2(400);
            run2(2 * total_of(a));
        end

        // Offer landing exactly on the frame's last cycle.
        n = 0;
        while (m_t != total_of(m_act) - 1 && n < 400) begin
            step2();
            n++;
        end
        a = rand_cfg();
        offer2(a);
        chk("coincident_pending", 32'(m_pend), 32'(1));
        wait_apply2(400);
        run2(total_of(a));

        // 1280x720: one full line after the switch.
        offer2(TIMING_1280X720);
        wait_apply2(400);
        cnt = 0;
        for (int i = 0; i < 1650; i++) begin
            step2();
            if (d2_hs === 1'b1) cnt++;
        end
        chk("hd_hsync_high", 32'(cnt), 32'(40));
        step2();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
